// File: rtl/fp32_arith_unit.sv
// Single-precision add/sub/mul/compare unit with one registered stage.
// Denormals flush to zero, rounding truncates, and the result is registered on the same edge that accepts the request.
module fp32_arith_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] result,
  output logic [1:0]  cmp_result,
  output logic        exception,
  output logic        overflow,
  output logic        underflow
);

  localparam int unsigned EW = 8;
  localparam int unsigned MW = 23;
  localparam int unsigned SW = MW + 1;
  localparam int unsigned XW = EW + 2;

  localparam logic [1:0]  OP_ADD = 2'b00;
  localparam logic [1:0]  OP_SUB = 2'b01;
  localparam logic [1:0]  OP_MUL = 2'b10;
  localparam logic [1:0]  OP_CMP = 2'b11;
  localparam logic [1:0]  CMP_GT = 2'b00;
  localparam logic [1:0]  CMP_EQ = 2'b01;
  localparam logic [1:0]  CMP_LT = 2'b10;
  localparam logic [1:0]  CMP_UN = 2'b11;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  function automatic logic [4:0] lzc24(input logic [SW-1:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) lzc24 = 5'(23 - i);
    end
  endfunction

  // Operand unpacking; a zero exponent field makes the operand a signed zero
  logic          sa, sb, sbx;
  logic [EW-1:0] ea, eb;
  logic [SW-1:0] ma, mb;
  logic          a_zero, b_zero, a_spec, b_spec, a_nan, b_nan;

  assign sa     = a[31];
  assign sb     = b[31];
  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign ma     = a_zero ? '0 : {1'b1, a[22:0]};
  assign mb     = b_zero ? '0 : {1'b1, b[22:0]};
  assign a_spec = (ea == '1);
  assign b_spec = (eb == '1);
  assign a_nan  = a_spec & (|a[22:0]);
  assign b_nan  = b_spec & (|b[22:0]);

  // Add/sub path
  logic                 swap, sl, ss, add_s, add_zero;
  logic [EW-1:0]        el, es, sh;
  logic [SW-1:0]        ml, ms, ms_al, diff;
  logic [SW:0]          sum;
  logic [4:0]           lz;
  logic signed [XW-1:0] add_e;
  logic [MW-1:0]        add_m;

  always_comb begin
    sbx      = sb ^ (op == OP_SUB);
    swap     = {ea, ma} < {eb, mb};
    sl       = swap ? sbx : sa;
    ss       = swap ? sa  : sbx;
    el       = swap ? eb  : ea;
    es       = swap ? ea  : eb;
    ml       = swap ? mb  : ma;
    ms       = swap ? ma  : mb;
    sh       = el - es;
    ms_al    = ms >> sh;
    sum      = {1'b0, ml} + {1'b0, ms_al};
    diff     = ml - ms_al;
    lz       = lzc24(diff);
    add_s    = sl;
    add_zero = 1'b0;
    add_e    = '0;
    add_m    = '0;
    if (sl == ss) begin
      add_zero = (sum == '0);
      if (sum[SW]) begin
        add_e = XW'(el) + XW'(1);
        add_m = sum[MW:1];
      end else begin
        add_e = XW'(el);
        add_m = sum[MW-1:0];
      end
    end else begin
      add_zero = (diff == '0);
      add_s    = add_zero ? 1'b0 : sl;
      add_e    = XW'(el) - XW'(lz);
      add_m    = MW'(diff << lz);
    end
  end

  // Multiply path: keep the top 25 product bits, normalise by the MSB
  logic [2*SW-1:0]      prod;
  logic [SW:0]          prod_hi;
  logic signed [XW-1:0] mul_e;
  logic [MW-1:0]        mul_m;

  always_comb begin
    prod    = ma * mb;
    prod_hi = (SW+1)'(prod >> MW);
    mul_e   = XW'(ea) + XW'(eb) + XW'(prod_hi[SW]) - XW'(127);
    mul_m   = prod_hi[SW] ? prod_hi[MW:1] : prod_hi[MW-1:0];
  end

  // Compare path: zeros of either sign are equal, negatives order by reversed magnitude
  logic [30:0] mag_a, mag_b;
  logic [1:0]  cmp_c;

  always_comb begin
    mag_a = a_zero ? '0 : a[30:0];
    mag_b = b_zero ? '0 : b[30:0];
    if (a_nan || b_nan)                 cmp_c = CMP_UN;
    else if (mag_a == '0 && mag_b == '0) cmp_c = CMP_EQ;
    else if (sa != sb)                  cmp_c = sa ? CMP_LT : CMP_GT;
    else if (mag_a == mag_b)            cmp_c = CMP_EQ;
    else if ((mag_a > mag_b) ^ sa)      cmp_c = CMP_GT;
    else                                cmp_c = CMP_LT;
  end

  // Result selection and range checks
  logic                 r_s, r_zero;
  logic signed [XW-1:0] r_e;
  logic [MW-1:0]        r_m;
  logic [31:0]          result_d, result_q;
  logic [1:0]           cmp_d, cmp_q;
  logic                 exc_d, exc_q, ovf_d, ovf_q, unf_d, unf_q, valid_q;

  always_comb begin
    result_d = '0;
    cmp_d    = CMP_GT;
    exc_d    = a_spec | b_spec;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    r_s      = (op == OP_MUL) ? (sa ^ sb) : add_s;
    r_e      = (op == OP_MUL) ? mul_e : add_e;
    r_m      = (op == OP_MUL) ? mul_m : add_m;
    r_zero   = (op == OP_MUL) ? (a_zero | b_zero) : add_zero;
    if (op == OP_CMP) begin
      cmp_d = cmp_c;
    end else if (exc_d) begin
      result_d = QNAN;
    end else if (r_zero) begin
      result_d = {r_s, 31'd0};
    end else if (r_e > XW'(254)) begin
      result_d = {r_s, 31'h7F80_0000};
      ovf_d    = 1'b1;
    end else if (r_e < XW'(1)) begin
      result_d = {r_s, 31'd0};
      unf_d    = 1'b1;
    end else begin
      result_d = {r_s, r_e[EW-1:0], r_m};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      cmp_q    <= '0;
      exc_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        cmp_q    <= cmp_d;
        exc_q    <= exc_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
      end
    end
  end

  assign out_valid  = valid_q;
  assign result     = result_q;
  assign cmp_result = cmp_q;
  assign exception  = exc_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_fp32_arith_unit.sv
// Scoreboard bench for fp32_arith_unit: expected results queued at issue, checked when out_valid appears.
module tb_fp32_arith_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic [31:0] result;
  logic [1:0]  cmp_result;
  logic        exception, overflow, underflow;

  typedef struct packed {
    logic [31:0] res;
    logic [1:0]  cmp;
    logic        exc;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;
  logic exp_v;

  fp32_arith_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .result     (result),
    .cmp_result (cmp_result),
    .exception  (exception),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected out_valid: whether a request was accepted at the previous edge
  always @(posedge clk or negedge rst) begin
    if (!rst) exp_v <= 1'b0;
    else      exp_v <= in_valid;
  end

  always @(negedge clk) begin
    if (mon_en && rst) begin
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          chk("sb_underrun", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result",     result,            e.res);
          chk("cmp_result", 32'(cmp_result),   32'(e.cmp));
          chk("exception",  32'(exception),    32'(e.exc));
          chk("overflow",   32'(overflow),     32'(e.ovf));
          chk("underflow",  32'(underflow),    32'(e.unf));
        end
      end
    end
  end

  task automatic send(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] r, input logic [1:0] c,
                      input logic e, input logic ov, input logic un);
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    a        = va;
    b        = vb;
    x.res = r; x.cmp = c; x.exc = e; x.ovf = ov; x.unf = un;
    sb_q.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    op       = 2'($urandom_range(0, 3));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_cmp"}, 32'(cmp_result), 32'd0);
    chk({tag, "_flags"}, {29'd0, exception, overflow, underflow}, 32'd0);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    op       = 2'b00;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #1 chk_outputs_zero("reset");
    @(negedge clk);
    #1 rst = 1'b1;

    // Reset dropped asynchronously while a request is in flight
    @(negedge clk);
    in_valid = 1'b1; op = 2'b10; a = 32'h40A0_0000; b = 32'hC282_0000;
    @(posedge clk);
    #1 chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b0;
    #1 chk_outputs_zero("async_reset");
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    mon_en = 1'b1;
    idle();

    // Add/sub
    send(2'b00, 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000, 2'b00, 0, 0, 0);
    send(2'b01, 32'h40A0_0000, 32'h430C_0000, 32'hC307_0000, 2'b00, 0, 0, 0);
    send(2'b01, 32'h41F0_0000, 32'h41F0_0000, 32'h0000_0000, 2'b00, 0, 0, 0);
    send(2'b00, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 2'b00, 0, 0, 0);
    send(2'b01, 32'h00C0_0000, 32'h0080_0000, 32'h0000_0000, 2'b00, 0, 0, 1);
    idle();
    // Mul
    send(2'b10, 32'h40A0_0000, 32'hC282_0000, 32'hC3A2_8000, 2'b00, 0, 0, 0);
    send(2'b10, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 2'b00, 0, 1, 0);
    send(2'b10, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 2'b00, 0, 0, 1);
    send(2'b10, 32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 2'b00, 0, 0, 0);
    send(2'b10, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 2'b00, 0, 0, 0);
    idle();
    idle();
    // Compare
    send(2'b11, 32'hC282_0000, 32'h41F0_0000, 32'h0, 2'b10, 0, 0, 0);
    send(2'b11, 32'h41F0_0000, 32'h41F0_0000, 32'h0, 2'b01, 0, 0, 0);
    send(2'b11, 32'h0000_0000, 32'h8000_0000, 32'h0, 2'b01, 0, 0, 0);
    send(2'b11, 32'h41F0_0000, 32'hC282_0000, 32'h0, 2'b00, 0, 0, 0);
    send(2'b11, 32'hC000_0000, 32'hBF80_0000, 32'h0, 2'b10, 0, 0, 0);
    // Exceptions
    send(2'b10, 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 2'b00, 1, 0, 0);
    send(2'b11, 32'h7FC0_0000, 32'h3F80_0000, 32'h0, 2'b11, 1, 0, 0);
    send(2'b11, 32'h7F80_0000, 32'h3F80_0000, 32'h0, 2'b00, 1, 0, 0);
    idle();
    // Throughput with mixed ops and a gap
    send(2'b00, 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000, 2'b00, 0, 0, 0);
    send(2'b10, 32'h40A0_0000, 32'hC282_0000, 32'hC3A2_8000, 2'b00, 0, 0, 0);
    send(2'b11, 32'hC282_0000, 32'h41F0_0000, 32'h0, 2'b10, 0, 0, 0);
    send(2'b01, 32'h40A0_0000, 32'h430C_0000, 32'hC307_0000, 2'b00, 0, 0, 0);
    idle();
    send(2'b11, 32'h41F0_0000, 32'h41F0_0000, 32'h0, 2'b01, 0, 0, 0);
    idle();

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp32_arith_unit.md
Name: fp32_arith_unit

Overview:
- Single-precision (IEEE-754 binary32) arithmetic unit that merges the add/subtract, multiply and magnitude-compare primitives into one registered datapath.
- The neuron core uses it to evaluate membrane and recovery equations and threshold tests.
- Fully pipelined: one operation accepted per cycle, result one cycle later.

Parameters:
- None (fixed binary32 format).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low; resets all registered outputs.
- in_valid  input  1  operation request; operands and op are sampled when high.
- op  input  2  00 add, 01 subtract (a-b), 10 multiply, 11 compare.
- a  input  32  operand A, binary32.
- b  input  32  operand B, binary32.
- out_valid  output  1  high for exactly one cycle when result/flags are valid.
- result  output  32  binary32 result (add/sub/mul); 0 for compare.
- cmp_result  output  2  compare code: 00 a>b, 01 a==b, 10 a<b, 11 unordered; 00 for non-compare ops.
- exception  output  1  an operand is Inf or NaN (exponent field 255).
- overflow  output  1  add/sub/mul result exponent exceeded 254.
- underflow  output  1  add/sub/mul result exponent below 1 (nonzero true result).

Behaviour:
- Reset (rst low, async): out_valid, result, cmp_result, exception, overflow, underflow all 0. A request in flight during reset is discarded.
- Latency: a request sampled at edge N (in_valid=1) produces outputs registered at that same edge N, visible after it, valid until the next edge.
- out_valid mirrors registered in_valid. Back-to-back requests are accepted every cycle. There is no stall or backpressure.
- When in_valid=0: out_valid deasserts next edge. Data outputs hold their last values.
- Input denormals (exp=0) are treated as signed zero. Output denormals flush to signed zero.
- Rounding is truncation (round toward zero) for add, sub and mul. Mantissas are computed with a 24-bit significand including the hidden 1.

Add/sub:
- Subtract is add with b's sign inverted.
- Align the smaller exponent by right shift, discarding shifted-out bits. Add or subtract magnitudes, then normalize with a leading-one shift.
- Exact cancellation gives +0.
- Result sign is the sign of the larger magnitude.

Mul:
- sign = sa^sb.
- exp = ea+eb-127, plus normalize +1 if the 48-bit product MSB is set.
- Mantissa is the top 23 bits after the hidden bit (truncated).
- A zero operand gives signed zero with no flags.

Overflow and underflow:
- Overflow: result = sign|0x7F800000, overflow=1.
- Underflow: result = signed zero, underflow=1.

Exception:
- Applies when either operand has exp=255. Set exception=1, overflow=underflow=0.
- result = 0x7FC00000 for arithmetic ops.

Compare:
- IEEE ordering: +0 equals -0. Negative values order by reversed magnitude.
- Either operand NaN: cmp_result=11, exception=1.
- Inf operands compare normally but still set exception=1.
- Threshold test by consumers: spike when cmp_result is 00 or 01 (a>=b).

Flags:
- All flags are registered with result and are valid only with out_valid.

Test Plan:
- Reset: drive rst low mid-operation with in_valid=1 -> all outputs 0 immediately (before any clock edge); no out_valid after release until a new request.
- Add/sub: op=00, a=0x40000000 (2.0), b=0x40400000 (3.0) -> result 0x40A00000 next cycle, flags 0. Then op=01, a=0x40A00000, b=0x430C0000 -> result 0xC3070000 (-135.0). Then op=01, a=b=0x41F00000 -> result 0x00000000.
- Mul: op=10, a=0x40A00000 (5.0), b=0xC2820000 (-65.0) -> result 0xC3A28000 (-325.0). Then a=0x7F000000, b=0x40000000 -> result 0x7F800000, overflow=1.
- Compare: op=11 with a=0xC2820000, b=0x41F00000 -> cmp_result 10. Then a=b=0x41F00000 -> 01. Then a=0x00000000, b=0x80000000 -> 01. Then a=0x41F00000, b=0xC2820000 -> 00.
- Exceptions: op=10, a=0x7F800000, b=0x3F800000 -> exception=1, result 0x7FC00000. Then op=11, a=0x7FC00000 -> cmp_result 11, exception=1.
- Throughput: four consecutive in_valid cycles with mixed ops -> four consecutive out_valid cycles, each with the correct result. A gap in in_valid produces a matching gap in out_valid.
